ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_line_sync.sv | 37 +++
 rtl/ps2_host_tx.sv | 217 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host-side blocks.
//   - ps2_state_t : host transmitter FSM encoding
//   - PS2_CMD_*   : common keyboard command bytes
//   - PS2_ACK_BYTE: byte the keyboard returns after accepting a command
//   - PS2_FRAME_BITS: host-driven bits after the start bit (8 data, parity, stop)
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

    localparam int PS2_FRAME_BITS = 10;

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: two-flop synchronizer for one raw PS/2 line plus
// edge detection on the synchronized level.
//   clk, reset : system clock, synchronous active-high reset
//   raw        : asynchronous line level
//   level      : synchronized level
//   fall, rise : one-cycle strobes on a synchronized high->low / low->high
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic fall,
    output logic rise
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    // Reset to the idle-high bus level so leaving reset creates no edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            prev_p2 <= 1'b1;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign fall  = prev_p2 & ~sync_p1;
    assign rise  = ~prev_p2 & sync_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Inhibits the bus, requests to send, then shifts out 8 data bits (LSB
// first), odd parity and stop on the device's falling clock edges, and
// checks the device ACK bit.
//   clk, reset            : system clock, synchronous active-high reset
//   tx_valid, tx_data     : command request and byte (accepted in IDLE only)
//   tx_ready / tx_busy    : IDLE / not IDLE
//   tx_done / tx_err      : one-cycle result pulses (ACK / NACK or timeout)
//   ps2_clk_in/ps2_dat_in : raw line levels (asynchronous)
//   ps2_clk_oe/ps2_dat_oe : 1 = pull the line low (open drain)
// Optional build macro PS2_HOST_TX_RETRY_EN: a failed frame is retried
// from INHIBIT up to two more times before tx_err is raised.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int RTS_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int PHASE_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int CNT_W     = $clog2(PHASE_MAX + 1);
    localparam int TOUT_W    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]  INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RTS_LAST     = CNT_W'(RTS_CYCLES - 1);
    localparam logic [TOUT_W-1:0] TOUT_LAST    = TOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]        STOP_IDX     = 4'(PS2_FRAME_BITS - 1);
    localparam logic [3:0]        PARITY_IDX   = 4'(PS2_FRAME_BITS - 2);

    logic clk_level, clk_fall, clk_rise;
    logic dat_level, dat_fall, dat_rise;
    logic unused_edges;

    ps2_line_sync u_clk_sync (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall),
        .rise  (clk_rise)
    );

    ps2_line_sync u_dat_sync (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_dat_in),
        .level (dat_level),
        .fall  (dat_fall),
        .rise  (dat_rise)
    );

    assign unused_edges = clk_rise | dat_fall | dat_rise;

    ps2_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [TOUT_W-1:0] tout;
    logic [3:0]        bit_idx;
    logic [7:0]        data_q;
    logic              parity_q;
    logic              timed_out;
    logic              fail_now;
`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0]        retry_cnt;
`endif

    // Byte and parity are captured only on acceptance; no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && tx_valid) begin
            data_q   <= tx_data;
            parity_q <= ~^tx_data;
        end
    end

    // Timeout takes priority over any edge arriving in the same cycle.
    always_comb begin
        timed_out = 1'b0;
        fail_now  = 1'b0;
        if (state == SEND || state == ACK || state == WAIT_IDLE) begin
            timed_out = (tout == TOUT_LAST);
        end
        fail_now = timed_out || (state == ACK && clk_fall && dat_level);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            tout       <= '0;
            bit_idx    <= '0;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_cnt  <= '0;
`endif
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            if (fail_now) begin
                ps2_dat_oe <= 1'b0;
                cnt        <= '0;
                tout       <= '0;
                bit_idx    <= '0;
`ifdef PS2_HOST_TX_RETRY_EN
                if (retry_cnt != 2'd2) begin
                    // Restart the same byte; the bus stays owned.
                    retry_cnt  <= retry_cnt + 2'd1;
                    ps2_clk_oe <= 1'b1;
                    state      <= INHIBIT;
                end else begin
                    ps2_clk_oe <= 1'b0;
                    tx_err     <= 1'b1;
                    tx_ready   <= 1'b1;
                    tx_busy    <= 1'b0;
                    state      <= IDLE;
                end
`else
                ps2_clk_oe <= 1'b0;
                tx_err     <= 1'b1;
                tx_ready   <= 1'b1;
                tx_busy    <= 1'b0;
                state      <= IDLE;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (tx_valid) begin
                            cnt        <= '0;
                            tx_ready   <= 1'b0;
                            tx_busy    <= 1'b1;
                            ps2_clk_oe <= 1'b1;
`ifdef PS2_HOST_TX_RETRY_EN
                            retry_cnt  <= '0;
`endif
                            state      <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (cnt == INHIBIT_LAST) begin
                            cnt        <= '0;
                            ps2_dat_oe <= 1'b1;
                            state      <= RTS;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RTS: begin
                        if (cnt == RTS_LAST) begin
                            cnt        <= '0;
                            tout       <= '0;
                            bit_idx    <= '0;
                            ps2_clk_oe <= 1'b0;
                            state      <= SEND;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    SEND: begin
                        tout <= tout + 1'b1;
                        if (clk_fall) begin
                            bit_idx <= bit_idx + 4'd1;
                            if (bit_idx < PARITY_IDX) begin
                                ps2_dat_oe <= ~data_q[bit_idx[2:0]];
                            end else if (bit_idx == PARITY_IDX) begin
                                ps2_dat_oe <= ~parity_q;
                            end else if (bit_idx == STOP_IDX) begin
                                ps2_dat_oe <= 1'b0;
                                state      <= ACK;
                            end
                        end
                    end
                    ACK: begin
                        // A high data level here is handled as a failure above.
                        tout <= tout + 1'b1;
                        if (clk_fall) begin
                            state <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        tout <= tout + 1'b1;
                        if (clk_level && dat_level) begin
                            tx_done  <= 1'b1;
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                    default: begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_ready   <= 1'b1;
                        tx_busy    <= 1'b0;
                        state      <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed testbench for ps2_host_tx with a PS/2 device
// model on wired-AND open-drain lines. Timing parameters are scaled down
// so every scenario, including the timeout, runs in a few thousand cycles.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 200;
    localparam int RTSN = 20;
    localparam int TOUT = 3000;
    localparam int HALF = 15;
`ifdef PS2_HOST_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk_low, dev_dat_low;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    always #10 clk = ~clk;

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .RTS_CYCLES     (RTSN),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always @(posedge clk) begin
        #1;
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (tx_done && tx_err) both_cnt++;
    end

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device model: measures inhibit/RTS, then clocks the frame and samples
    // each host bit on the rising edge. Returns early after the low phase of
    // clock stop_at when stop_at is nonzero.
    task automatic run_dev(input bit do_ack, input bit do_clock, input int stop_at,
                           output int inh, output int rts, output logic [9:0] bits,
                           output logic start_lvl);
        inh = 0; rts = 0; bits = '0; start_lvl = 1'b1;
        while (ps2_clk_oe && !ps2_dat_oe && inh < 4 * INH) begin inh++; @(negedge clk); end
        while (ps2_clk_oe && ps2_dat_oe && rts < 4 * RTSN) begin rts++; @(negedge clk); end
        if (!do_clock) return;
        start_lvl = ps2_dat_in;
        repeat (5) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (k == stop_at) return;
            dev_clk_low = 1'b0;
            if (k <= 10) bits[k-1] = ps2_dat_in;
            if (k == 10) dev_dat_low = do_ack;
            repeat (HALF) @(negedge clk);
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_pulse(input int base_done, input int base_err, input int limit);
        int n = 0;
        while (done_cnt == base_done && err_cnt == base_err && n < limit) begin
            @(negedge clk); n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        dev_clk_low = 1'b0; dev_dat_low = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", tx_done); end
        n_checks++; if (tx_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", tx_err); end
        n_checks++; if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
        n_checks++; if (ps2_dat_oe !== 1'b0) begin n_fail++; $display("FAIL reset_dat_oe: got %b want 0", ps2_dat_oe); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_send_ed();
        int inh, rts, bd, be;
        logic [9:0] bits;
        logic st;
        bd = done_cnt; be = err_cnt;
        send_cmd(PS2_CMD_SET_LED);
        n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL ed_busy: got %b want 1", tx_busy); end
        run_dev(1'b1, 1'b1, 0, inh, rts, bits, st);
        wait_pulse(bd, be, 40);
        n_checks++; if (inh !== INH) begin n_fail++; $display("FAIL ed_inhibit_len: got %0d want %0d", inh, INH); end
        n_checks++; if (rts !== RTSN) begin n_fail++; $display("FAIL ed_rts_len: got %0d want %0d", rts, RTSN); end
        n_checks++; if (st !== 1'b0) begin n_fail++; $display("FAIL ed_start_bit: got %b want 0", st); end
        n_checks++; if (bits !== 10'h3ED) begin n_fail++; $display("FAIL ed_frame: got %h want 3ed", bits); end
        n_checks++; if (done_cnt !== bd + 1) begin n_fail++; $display("FAIL ed_done: got %0d want %0d", done_cnt, bd + 1); end
        n_checks++; if (err_cnt !== be) begin n_fail++; $display("FAIL ed_err: got %0d want %0d", err_cnt, be); end
        @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin n_fail++; $display("FAIL ed_idle: got rdy=%b clk_oe=%b dat_oe=%b want 1 0 0", tx_ready, ps2_clk_oe, ps2_dat_oe); end
    endtask

    task automatic test_back_to_back();
        int inh, rts, bd, be;
        logic [9:0] bits;
        logic st;
        bd = done_cnt; be = err_cnt;
        send_cmd(PS2_CMD_ENABLE);
        run_dev(1'b1, 1'b1, 0, inh, rts, bits, st);
        wait_pulse(bd, be, 40);
        n_checks++; if (bits !== 10'h2F4) begin n_fail++; $display("FAIL f4_frame: got %h want 2f4", bits); end
        n_checks++; if (bits[8] !== 1'b0) begin n_fail++; $display("FAIL f4_parity: got %b want 0", bits[8]); end
        n_checks++; if (done_cnt !== bd + 1) begin n_fail++; $display("FAIL f4_done: got %0d want %0d", done_cnt, bd + 1); end
        // Next byte issued right after the done pulse.
        bd = done_cnt;
        send_cmd(PS2_CMD_RESET);
        run_dev(1'b1, 1'b1, 0, inh, rts, bits, st);
        wait_pulse(bd, be, 40);
        n_checks++; if (inh !== INH) begin n_fail++; $display("FAIL ff_inhibit_len: got %0d want %0d", inh, INH); end
        n_checks++; if (bits !== 10'h3FF) begin n_fail++; $display("FAIL ff_frame: got %h want 3ff", bits); end
        n_checks++; if (bits[8] !== 1'b1) begin n_fail++; $display("FAIL ff_parity: got %b want 1", bits[8]); end
        n_checks++; if (done_cnt !== bd + 1 || err_cnt !== be) begin n_fail++; $display("FAIL ff_result: got done=%0d err=%0d want %0d %0d", done_cnt, err_cnt, bd + 1, be); end
    endtask

    task automatic test_nack();
        int inh, rts, bd, be, attempts;
        logic [9:0] bits;
        logic st;
        bd = done_cnt; be = err_cnt; attempts = 0;
        send_cmd(PS2_CMD_ENABLE);
        for (int a = 0; a < ATTEMPTS; a++) begin
            run_dev(1'b0, 1'b1, 0, inh, rts, bits, st);
            if (inh > 0) attempts++;
            if (a < ATTEMPTS - 1) begin
                n_checks++; if (err_cnt !== be) begin n_fail++; $display("FAIL nack_early_err: got %0d want %0d", err_cnt, be); end
            end
        end
        wait_pulse(bd, be, 40);
        n_checks++; if (attempts !== ATTEMPTS) begin n_fail++; $display("FAIL nack_attempts: got %0d want %0d", attempts, ATTEMPTS); end
        n_checks++; if (err_cnt !== be + 1) begin n_fail++; $display("FAIL nack_err: got %0d want %0d", err_cnt, be + 1); end
        n_checks++; if (done_cnt !== bd) begin n_fail++; $display("FAIL nack_done: got %0d want %0d", done_cnt, bd); end
        @(negedge clk);
        n_checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || tx_ready !== 1'b1) begin n_fail++; $display("FAIL nack_idle: got clk_oe=%b dat_oe=%b rdy=%b want 0 0 1", ps2_clk_oe, ps2_dat_oe, tx_ready); end
    endtask

    task automatic test_timeout();
        int inh, rts, bd, be, n;
        logic [9:0] bits;
        logic st;
        bd = done_cnt; be = err_cnt; n = 0;
        send_cmd(PS2_CMD_RESET);
        run_dev(1'b0, 1'b0, 0, inh, rts, bits, st);
        n_checks++; if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL to_clk_release: got %b want 0", ps2_clk_oe); end
        while (!(tx_err || ps2_clk_oe) && n < TOUT + 100) begin @(negedge clk); n++; end
        n_checks++; if (n !== TOUT) begin n_fail++; $display("FAIL to_length: got %0d want %0d", n, TOUT); end
        wait_pulse(bd, be, ATTEMPTS * (INH + RTSN + TOUT + 10));
        n_checks++; if (err_cnt !== be + 1 || done_cnt !== bd) begin n_fail++; $display("FAIL to_result: got err=%0d done=%0d want %0d %0d", err_cnt, done_cnt, be + 1, bd); end
        @(negedge clk);
        n_checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin n_fail++; $display("FAIL to_release: got clk_oe=%b dat_oe=%b want 0 0", ps2_clk_oe, ps2_dat_oe); end
    endtask

    task automatic test_reset_mid();
        int inh, rts, bd, be;
        logic [9:0] bits;
        logic st;
        bd = done_cnt; be = err_cnt;
        send_cmd(PS2_CMD_SET_LED);
        run_dev(1'b1, 1'b1, 4, inh, rts, bits, st);
        n_checks++; if (ps2_clk_oe !== 1'b0 || tx_busy !== 1'b1) begin n_fail++; $display("FAIL mid_in_frame: got clk_oe=%b busy=%b want 0 1", ps2_clk_oe, tx_busy); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin n_fail++; $display("FAIL mid_release: got clk_oe=%b dat_oe=%b want 0 0", ps2_clk_oe, ps2_dat_oe); end
        n_checks++; if (tx_ready !== 1'b1 || tx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got rdy=%b busy=%b want 1 0", tx_ready, tx_busy); end
        reset = 1'b0;
        dev_clk_low = 1'b0;
        repeat (40) @(negedge clk);
        n_checks++; if (done_cnt !== bd || err_cnt !== be) begin n_fail++; $display("FAIL mid_no_pulse: got done=%0d err=%0d want %0d %0d", done_cnt, err_cnt, bd, be); end
    endtask

    task automatic test_ignore_valid();
        int inh, rts, bd, be;
        logic [9:0] bits;
        logic st;
        bd = done_cnt; be = err_cnt;
        send_cmd(PS2_CMD_SET_LED);
        fork
            run_dev(1'b1, 1'b1, 0, inh, rts, bits, st);
            begin
                repeat (50) @(negedge clk);
                tx_data = 8'h00; tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                repeat (250) @(negedge clk);
                tx_data = 8'h00; tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        wait_pulse(bd, be, 40);
        n_checks++; if (inh !== INH) begin n_fail++; $display("FAIL ign_inhibit_len: got %0d want %0d", inh, INH); end
        n_checks++; if (bits !== 10'h3ED) begin n_fail++; $display("FAIL ign_frame: got %h want 3ed", bits); end
        n_checks++; if (done_cnt !== bd + 1) begin n_fail++; $display("FAIL ign_done: got %0d want %0d", done_cnt, bd + 1); end
        repeat (20) @(negedge clk);
        n_checks++; if (ps2_clk_oe !== 1'b0 || tx_ready !== 1'b1) begin n_fail++; $display("FAIL ign_no_new_frame: got clk_oe=%b rdy=%b want 0 1", ps2_clk_oe, tx_ready); end
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL done_err_together: got %0d want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_back_to_back();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_ignore_valid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
